// File: rtl/serial_alu_if.sv
// serial_alu_if: operand/result valid-ready bundle for serial_alu
interface serial_alu_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             ovf;
  modport master (output in_valid, a, b, op, out_ready,
                  input  in_ready, out_valid, result, cout, zero, ovf);
  modport slave  (input  in_valid, a, b, op, out_ready,
                  output in_ready, out_valid, result, cout, zero, ovf);
endinterface

// File: rtl/serial_alu.sv
// serial_alu: SLICE-bits-per-clock AND/OR/ADD/SUB with carry kept between beats
module serial_alu #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input logic         clk,
  input logic         rst_n,
  serial_alu_if.slave bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  if (WIDTH % SLICE != 0) begin : g_cfg_err
    $error("serial_alu: WIDTH must be a multiple of SLICE");
  end
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;
  logic             amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic [SLICE-1:0]       as, bs, slice_res;
  logic [SLICE:0]         sum;
  logic [WIDTH+SLICE-1:0] cat;
  logic [WIDTH-1:0]       res_n;
  logic                   c_n, r_msb, ovf_n;
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.result    = res_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  // one slice of the datapath: SUB inverts B and rides the carry chain seeded with 1
  always_comb begin
    as        = a_q[SLICE-1:0];
    bs        = op_q == 2'b11 ? ~b_q[SLICE-1:0] : b_q[SLICE-1:0];
    sum       = {1'b0, as} + {1'b0, bs} + {{SLICE{1'b0}}, carry_q};
    slice_res = op_q == 2'b00 ? (as & bs) : op_q == 2'b01 ? (as | bs) : sum[SLICE-1:0];
    c_n       = op_q[1] ? sum[SLICE] : 1'b0;
    cat       = {slice_res, res_q};
    res_n     = cat[WIDTH+SLICE-1:SLICE];
    r_msb     = res_n[WIDTH-1];
    ovf_n     = op_q == 2'b10 ? (amsb_q == bmsb_q) & (r_msb != amsb_q) :
                op_q == 2'b11 ? (amsb_q != bmsb_q) & (r_msb != amsb_q) : 1'b0;
  end
  // next-state: accept in IDLE, shift one slice per beat in RUN, hold in DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = RUN;
        a_d     = bus.a;
        b_d     = bus.b;
        op_d    = bus.op;
        amsb_d  = bus.a[WIDTH-1];
        bmsb_d  = bus.b[WIDTH-1];
        carry_d = bus.op == 2'b11;
        cnt_d   = '0;
        res_d   = '0;
        cout_d  = 1'b0;
        zero_d  = 1'b0;
        ovf_d   = 1'b0;
      end
      RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        res_d   = res_n;
        carry_d = c_n;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          cout_d  = c_n;
          zero_d  = res_n == '0;
          ovf_d   = ovf_n;
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
    end
  end
endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: directed vectors for serial_alu at SLICE=1 and SLICE=4
module tb_serial_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;
  serial_alu_if #(.WIDTH(8)) s1 ();
  serial_alu_if #(.WIDTH(8)) s4 ();
  serial_alu #(.WIDTH(8), .SLICE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(s1.slave));
  serial_alu #(.WIDTH(8), .SLICE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(s4.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic run1(input string tag, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic ec, input logic ez, input logic eo);
    int cyc;
    chk({tag, "_in_ready"}, 32'(s1.in_ready), 32'd1);
    s1.in_valid = 1'b1;
    s1.a = a;
    s1.b = b;
    s1.op = op;
    @(posedge clk);
    #1;
    s1.in_valid = 1'b0;
    s1.a = 8'($urandom);
    s1.b = 8'($urandom);
    cyc = 0;
    while (!s1.out_valid && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'd8);
    chk({tag, "_result"}, 32'(s1.result), 32'(er));
    chk({tag, "_cout"}, 32'(s1.cout), 32'(ec));
    chk({tag, "_zero"}, 32'(s1.zero), 32'(ez));
    chk({tag, "_ovf"}, 32'(s1.ovf), 32'(eo));
    s1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    s1.out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(s1.in_ready), 32'd1);
    chk({tag, "_ov_low"}, 32'(s1.out_valid), 32'd0);
  endtask
  initial begin
    int cyc;
    s1.in_valid = 1'b0; s1.a = '0; s1.b = '0; s1.op = '0; s1.out_ready = 1'b0;
    s4.in_valid = 1'b0; s4.a = '0; s4.b = '0; s4.op = '0; s4.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(s1.in_ready), 32'd1);
    chk("rst_out_valid", 32'(s1.out_valid), 32'd0);
    chk("rst_flags", {s1.result, s1.cout, s1.zero, s1.ovf}, 32'd0);
    chk("rst4_flags", {s4.out_valid, s4.result, s4.cout, s4.zero, s4.ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run1("add_ff_01", 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    run1("sub_80_01", 2'b11, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1);
    run1("sub_00_01", 2'b11, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
    run1("and", 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    run1("or", 2'b01, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0);
    run1("sub_eq", 2'b11, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b1, 1'b0);
    // backpressure: ADD 0x40+0x40 = 0x80 with signed overflow
    s1.in_valid = 1'b1; s1.a = 8'h40; s1.b = 8'h40; s1.op = 2'b10;
    @(posedge clk);
    #1 s1.in_valid = 1'b0;
    cyc = 0;
    while (!s1.out_valid && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("bp_lat", 32'(cyc), 32'd8);
    for (int i = 0; i < 5; i++) begin
      s1.in_valid = ~s1.in_valid;
      s1.a = 8'($urandom);
      s1.b = 8'($urandom);
      s1.op = 2'($urandom);
      @(posedge clk);
      #1;
      chk("bp_hold", {s1.out_valid, s1.in_ready, s1.result, s1.cout, s1.zero, s1.ovf},
          {1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1});
    end
    s1.in_valid = 1'b0;
    s1.out_ready = 1'b1;
    @(posedge clk);
    #1 s1.out_ready = 1'b0;
    chk("bp_release", {s1.in_ready, s1.out_valid}, 32'b10);
    @(posedge clk);
    #1;
    chk("bp_no_accept", {s1.in_ready, s1.out_valid}, 32'b10);
    // reset during beat 3 of an ADD
    s1.in_valid = 1'b1; s1.a = 8'h55; s1.b = 8'h0F; s1.op = 2'b10;
    @(posedge clk);
    #1 s1.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {s1.out_valid, s1.result, s1.cout, s1.zero, s1.ovf}, 32'd0);
    chk("abort_in_ready", 32'(s1.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run1("add_after_abort", 2'b10, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);
    // SLICE=4: two beats per operation
    s4.in_valid = 1'b1; s4.a = 8'h7F; s4.b = 8'h01; s4.op = 2'b10;
    @(posedge clk);
    #1 s4.in_valid = 1'b0;
    cyc = 0;
    while (!s4.out_valid && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("s4_lat", 32'(cyc), 32'd2);
    chk("s4_result", 32'(s4.result), 32'h80);
    chk("s4_flags", {s4.cout, s4.zero, s4.ovf}, 32'b001);
    s4.out_ready = 1'b1;
    @(posedge clk);
    #1 s4.out_ready = 1'b0;
    chk("s4_idle", 32'(s4.in_ready), 32'd1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
